// File: rtl/evm_vote_tally_if.sv
// Bus between the EVM voting FSM / host and the vote tally stage.
// master drives votes, control and read select; slave returns counts and result.
interface evm_vote_tally_if #(
    parameter int CNT_W = 8
);
    logic               vote_valid;
    logic [1:0]         incr_party_vote;
    logic               seal;
    logic               result_req;
    logic [1:0]         rd_sel;
    logic [CNT_W-1:0]   rd_count;
    logic [CNT_W+1:0]   total_votes;
    logic               vote_ack;
    logic               overflow;
    logic               sealed;
    logic               result_valid;
    logic [1:0]         winner;
    logic [CNT_W-1:0]   winner_votes;
    logic               tie;

    modport master (
        output vote_valid, incr_party_vote, seal, result_req, rd_sel,
        input  rd_count, total_votes, vote_ack, overflow, sealed,
        input  result_valid, winner, winner_votes, tie
    );

    modport slave (
        input  vote_valid, incr_party_vote, seal, result_req, rd_sel,
        output rd_count, total_votes, vote_ack, overflow, sealed,
        output result_valid, winner, winner_votes, tie
    );
endinterface

// File: rtl/evm_vote_tally.sv
// Saturating four-party vote tally with seal, sequential winner search and read port.
// Handshake: one vote is taken per rising edge of vote_valid; vote_ack pulses one cycle later.
module evm_vote_tally #(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    evm_vote_tally_if.slave     bus,
    output logic [2:0]          dbg_state_o
);
    localparam int TOT_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_COUNT   = 3'd0,
        S_SEALED  = 3'd1,
        S_COMPARE = 3'd2,
        S_RESULT  = 3'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [TOT_W-1:0]       total_q, total_d;
    logic                   ack_q, ack_d;
    logic                   ovf_q, ovf_d;
    logic                   vote_valid_q;
    logic [CNT_W-1:0]       rd_count_q;
    logic [1:0]             idx_q, idx_d;
    logic [CNT_W-1:0]       best_q, best_d;
    logic [1:0]             best_idx_q, best_idx_d;
    logic                   tie_acc_q, tie_acc_d;
    logic [1:0]             winner_q, winner_d;
    logic [CNT_W-1:0]       winner_votes_q, winner_votes_d;
    logic                   tie_q, tie_d;
    logic                   accept;

    assign accept = bus.vote_valid & ~vote_valid_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        total_d        = total_q;
        ack_d          = 1'b0;
        ovf_d          = ovf_q;
        idx_d          = idx_q;
        best_d         = best_q;
        best_idx_d     = best_idx_q;
        tie_acc_d      = tie_acc_q;
        winner_d       = winner_q;
        winner_votes_d = winner_votes_q;
        tie_d          = tie_q;

        case (state_q)
            S_COUNT: begin
                if (accept) begin
                    if (cnt_q[bus.incr_party_vote] != CNT_MAX) begin
                        cnt_d[bus.incr_party_vote] = cnt_q[bus.incr_party_vote] + CNT_W'(1);
                        total_d = total_q + TOT_W'(1);
                        ack_d   = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (bus.seal) begin
                    state_d = S_SEALED;
                end
            end
            S_SEALED: begin
                if (bus.result_req) begin
                    state_d = S_COMPARE;
                    idx_d   = 2'd0;
                end
            end
            S_COMPARE: begin
                // Strict greater-than keeps the lowest index on ties.
                if (idx_q == 2'd0) begin
                    best_d     = cnt_q[0];
                    best_idx_d = 2'd0;
                    tie_acc_d  = 1'b0;
                end else if (cnt_q[idx_q] > best_q) begin
                    best_d     = cnt_q[idx_q];
                    best_idx_d = idx_q;
                    tie_acc_d  = 1'b0;
                end else if (cnt_q[idx_q] == best_q) begin
                    tie_acc_d  = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    state_d        = S_RESULT;
                    winner_d       = best_idx_d;
                    winner_votes_d = best_d;
                    tie_d          = tie_acc_d;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            S_RESULT: begin
                state_d = S_RESULT;
            end
            default: begin
                state_d = S_COUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_COUNT;
            cnt_q          <= '0;
            total_q        <= '0;
            ack_q          <= 1'b0;
            ovf_q          <= 1'b0;
            vote_valid_q   <= 1'b0;
            rd_count_q     <= '0;
            idx_q          <= 2'd0;
            best_q         <= '0;
            best_idx_q     <= 2'd0;
            tie_acc_q      <= 1'b0;
            winner_q       <= 2'd0;
            winner_votes_q <= '0;
            tie_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            total_q        <= total_d;
            ack_q          <= ack_d;
            ovf_q          <= ovf_d;
            vote_valid_q   <= bus.vote_valid;
            rd_count_q     <= cnt_q[bus.rd_sel];
            idx_q          <= idx_d;
            best_q         <= best_d;
            best_idx_q     <= best_idx_d;
            tie_acc_q      <= tie_acc_d;
            winner_q       <= winner_d;
            winner_votes_q <= winner_votes_d;
            tie_q          <= tie_d;
        end
    end

    assign bus.rd_count     = rd_count_q;
    assign bus.total_votes  = total_q;
    assign bus.vote_ack     = ack_q;
    assign bus.overflow     = ovf_q;
    assign bus.sealed       = (state_q == S_SEALED) || (state_q == S_COMPARE) ||
                              (state_q == S_RESULT);
    assign bus.result_valid = (state_q == S_RESULT);
    assign bus.winner       = winner_q;
    assign bus.winner_votes = winner_votes_q;
    assign bus.tie          = tie_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_evm_vote_tally.sv
// Directed checks of the vote tally: counting, edge detect, saturation, seal, winner search, reset.
module tb_evm_vote_tally;
    logic clk;
    logic reset;
    logic [2:0] dbg_state8;
    logic [2:0] dbg_state2;
    int n_checks;
    int n_fail;
    int ack_sum;

    evm_vote_tally_if #(.CNT_W(8)) bus8 ();
    evm_vote_tally_if #(.CNT_W(2)) bus2 ();

    evm_vote_tally #(.CNT_W(8)) u_dut8 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus8.slave),
        .dbg_state_o (dbg_state8)
    );

    evm_vote_tally #(.CNT_W(2)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus2.slave),
        .dbg_state_o (dbg_state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe on the 8-bit instance; ack is checked right after the accepting edge.
    task automatic vote8(input logic [1:0] party, input logic exp_ack);
        bus8.incr_party_vote = party;
        bus8.vote_valid = 1'b1;
        tick(1);
        chk("vote8_ack", 32'(bus8.vote_ack), 32'(exp_ack));
        bus8.vote_valid = 1'b0;
        tick(1);
        chk("vote8_ack_clear", 32'(bus8.vote_ack), 32'd0);
    endtask

    task automatic vote2(input logic [1:0] party, input logic exp_ack);
        bus2.incr_party_vote = party;
        bus2.vote_valid = 1'b1;
        tick(1);
        chk("vote2_ack", 32'(bus2.vote_ack), 32'(exp_ack));
        bus2.vote_valid = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus8.vote_valid = 1'b0; bus8.incr_party_vote = 2'd0; bus8.seal = 1'b0;
        bus8.result_req = 1'b0; bus8.rd_sel = 2'd0;
        bus2.vote_valid = 1'b0; bus2.incr_party_vote = 2'd0; bus2.seal = 1'b0;
        bus2.result_req = 1'b0; bus2.rd_sel = 2'd0;
        tick(2);

        // Reset values
        chk("rst_rd_count", 32'(bus8.rd_count), 32'd0);
        chk("rst_total", 32'(bus8.total_votes), 32'd0);
        chk("rst_ack", 32'(bus8.vote_ack), 32'd0);
        chk("rst_overflow", 32'(bus8.overflow), 32'd0);
        chk("rst_sealed", 32'(bus8.sealed), 32'd0);
        chk("rst_result_valid", 32'(bus8.result_valid), 32'd0);
        chk("rst_winner", 32'(bus8.winner), 32'd0);
        chk("rst_winner_votes", 32'(bus8.winner_votes), 32'd0);
        chk("rst_tie", 32'(bus8.tie), 32'd0);
        chk("rst_state", 32'(dbg_state8), 32'd0);
        reset = 1'b0;
        tick(1);

        // Votes 2,0,2,3,2 then seal and compute
        vote8(2'd2, 1'b1);
        vote8(2'd0, 1'b1);
        vote8(2'd2, 1'b1);
        vote8(2'd3, 1'b1);
        vote8(2'd2, 1'b1);
        bus8.rd_sel = 2'd2;
        tick(1);
        chk("t1_rd_count_p2", 32'(bus8.rd_count), 32'd3);
        chk("t1_total", 32'(bus8.total_votes), 32'd5);
        bus8.seal = 1'b1;
        tick(1);
        bus8.seal = 1'b0;
        chk("t1_sealed", 32'(bus8.sealed), 32'd1);
        chk("t1_rv_sealed", 32'(bus8.result_valid), 32'd0);
        bus8.result_req = 1'b1;
        tick(1);
        bus8.result_req = 1'b0;
        chk("t1_state_compare", 32'(dbg_state8), 32'd2);
        chk("t1_winner_pre", 32'(bus8.winner), 32'd0);
        tick(3);
        chk("t1_rv_n4", 32'(bus8.result_valid), 32'd0);
        tick(1);
        chk("t1_rv_n5", 32'(bus8.result_valid), 32'd1);
        chk("t1_winner", 32'(bus8.winner), 32'd2);
        chk("t1_winner_votes", 32'(bus8.winner_votes), 32'd3);
        chk("t1_tie", 32'(bus8.tie), 32'd0);
        chk("t1_sealed_result", 32'(bus8.sealed), 32'd1);

        // Held strobe (already high as reset releases) counts once
        reset = 1'b1;
        bus8.incr_party_vote = 2'd1;
        bus8.vote_valid = 1'b1;
        tick(2);
        reset = 1'b0;
        ack_sum = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            ack_sum += int'(bus8.vote_ack);
        end
        bus8.vote_valid = 1'b0;
        chk("t2_ack_count", 32'(ack_sum), 32'd1);
        bus8.rd_sel = 2'd1;
        tick(1);
        chk("t2_rd_count_p1", 32'(bus8.rd_count), 32'd1);
        chk("t2_total", 32'(bus8.total_votes), 32'd1);

        // Saturation on the 2-bit instance
        vote2(2'd0, 1'b1);
        vote2(2'd0, 1'b1);
        vote2(2'd0, 1'b1);
        chk("t3_overflow_pre", 32'(bus2.overflow), 32'd0);
        vote2(2'd0, 1'b0);
        chk("t3_overflow", 32'(bus2.overflow), 32'd1);
        chk("t3_total", 32'(bus2.total_votes), 32'd3);
        bus2.rd_sel = 2'd0;
        tick(1);
        chk("t3_rd_count_p0", 32'(bus2.rd_count), 32'd3);
        vote2(2'd1, 1'b1);
        tick(3);
        chk("t3_overflow_sticky", 32'(bus2.overflow), 32'd1);
        chk("t3_total_after", 32'(bus2.total_votes), 32'd4);

        // Tie between 1 and 3, lowest index wins
        do_reset();
        vote8(2'd1, 1'b1);
        vote8(2'd3, 1'b1);
        vote8(2'd1, 1'b1);
        vote8(2'd3, 1'b1);
        bus8.seal = 1'b1;
        tick(1);
        bus8.seal = 1'b0;
        bus8.result_req = 1'b1;
        tick(1);
        bus8.result_req = 1'b0;
        tick(4);
        chk("t4_rv", 32'(bus8.result_valid), 32'd1);
        chk("t4_winner", 32'(bus8.winner), 32'd1);
        chk("t4_winner_votes", 32'(bus8.winner_votes), 32'd2);
        chk("t4_tie", 32'(bus8.tie), 32'd1);
        // RESULT ignores everything but reset
        bus8.seal = 1'b1;
        bus8.result_req = 1'b1;
        bus8.incr_party_vote = 2'd2;
        bus8.vote_valid = 1'b1;
        tick(2);
        bus8.seal = 1'b0;
        bus8.result_req = 1'b0;
        bus8.vote_valid = 1'b0;
        chk("t4_rv_hold", 32'(bus8.result_valid), 32'd1);
        chk("t4_winner_hold", 32'(bus8.winner), 32'd1);
        chk("t4_total_hold", 32'(bus8.total_votes), 32'd4);
        chk("t4_ack_hold", 32'(bus8.vote_ack), 32'd0);

        // No votes at all
        do_reset();
        bus8.seal = 1'b1;
        tick(1);
        bus8.seal = 1'b0;
        bus8.result_req = 1'b1;
        tick(1);
        bus8.result_req = 1'b0;
        tick(4);
        chk("t4z_rv", 32'(bus8.result_valid), 32'd1);
        chk("t4z_winner", 32'(bus8.winner), 32'd0);
        chk("t4z_winner_votes", 32'(bus8.winner_votes), 32'd0);
        chk("t4z_tie", 32'(bus8.tie), 32'd1);

        // result_req in COUNT, then vote and seal together
        do_reset();
        bus8.result_req = 1'b1;
        tick(1);
        bus8.result_req = 1'b0;
        chk("t5_req_in_count_state", 32'(dbg_state8), 32'd0);
        chk("t5_req_in_count_sealed", 32'(bus8.sealed), 32'd0);
        bus8.incr_party_vote = 2'd3;
        bus8.vote_valid = 1'b1;
        bus8.seal = 1'b1;
        tick(1);
        bus8.vote_valid = 1'b0;
        bus8.seal = 1'b0;
        chk("t5_seal_vote_ack", 32'(bus8.vote_ack), 32'd1);
        chk("t5_sealed", 32'(bus8.sealed), 32'd1);
        tick(1);
        vote8(2'd0, 1'b0);
        vote8(2'd3, 1'b0);
        chk("t5_total", 32'(bus8.total_votes), 32'd1);
        bus8.rd_sel = 2'd3;
        tick(1);
        chk("t5_rd_count_p3", 32'(bus8.rd_count), 32'd1);
        bus8.rd_sel = 2'd0;
        tick(1);
        chk("t5_rd_count_p0", 32'(bus8.rd_count), 32'd0);

        // Reset in the middle of COMPARE
        do_reset();
        vote8(2'd2, 1'b1);
        vote8(2'd2, 1'b1);
        bus8.seal = 1'b1;
        tick(1);
        bus8.seal = 1'b0;
        bus8.result_req = 1'b1;
        tick(1);
        bus8.result_req = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t6_state", 32'(dbg_state8), 32'd0);
        chk("t6_sealed", 32'(bus8.sealed), 32'd0);
        chk("t6_rv", 32'(bus8.result_valid), 32'd0);
        chk("t6_total", 32'(bus8.total_votes), 32'd0);
        chk("t6_winner_votes", 32'(bus8.winner_votes), 32'd0);
        bus8.rd_sel = 2'd2;
        tick(1);
        chk("t6_rd_count_p2", 32'(bus8.rd_count), 32'd0);
        vote8(2'd1, 1'b1);
        chk("t6_total_new", 32'(bus8.total_votes), 32'd1);
        bus8.rd_sel = 2'd1;
        tick(1);
        chk("t6_rd_count_p1", 32'(bus8.rd_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/evm_vote_tally.md
Name: evm_vote_tally

Overview:
- Vote counter stage directly downstream of the EVM voting FSM.
- Consumes the FSM's 2-bit party code `incr_party_vote` together with a vote strobe, and keeps four saturating per-party counters plus a running total.
- Once sealed, and on request, runs a sequential 4-cycle comparison to declare the winner and flag a tie.
- Provides a registered read port for the individual party counts.

Parameters:
- CNT_W, 8, width of each per-party counter; saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- vote_valid  input  1  vote strobe from the FSM; level input, one vote per rising edge.
- incr_party_vote  input  2  party code 0..3, sampled in the cycle a vote_valid rising edge is detected.
- seal  input  1  closes polling; honoured only in COUNT.
- result_req  input  1  starts the winner computation; honoured only in SEALED.
- rd_sel  input  2  party select for the read port.
- rd_count  output  CNT_W  count of the party selected by rd_sel, registered.
- total_votes  output  CNT_W+2  sum of all accepted votes.
- vote_ack  output  1  one-cycle pulse for each accepted vote.
- overflow  output  1  sticky; a vote was dropped because its party counter was saturated.
- sealed  output  1  high in SEALED, COMPARE and RESULT.
- result_valid  output  1  high in RESULT.
- winner  output  2  index of the winning party.
- winner_votes  output  CNT_W  vote count of the winner.
- tie  output  1  another party equals the winner's count.

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high on `reset`.
- Reset values: all counters, total_votes, rd_count, winner, winner_votes = 0; vote_ack, overflow, sealed, result_valid, tie = 0; state = COUNT; vote_valid_q (edge register) = 0.
- Edge detect: accept = vote_valid & ~vote_valid_q.
  - vote_valid held high for N cycles counts as exactly one vote.
  - vote_valid already high in the first cycle after reset counts as one vote.
- State COUNT:
  - On accept with counter[incr_party_vote] < max: that counter +1, total_votes +1, vote_ack = 1 on the next cycle (registered pulse, one cycle wide).
  - On accept with the counter == max: no increment, total unchanged, no vote_ack, overflow set and held until reset.
  - seal = 1 moves to SEALED next cycle. A vote accepted in the same cycle as seal is still counted and acked.
- State SEALED:
  - vote_valid is ignored; no counting and no ack.
  - result_req = 1 moves to COMPARE with idx = 0.
- State COMPARE: one party evaluated per cycle, idx 0..3.
  - idx 0: best = cnt0, best_idx = 0, tie = 0.
  - idx k > 0, cnt_k > best: best = cnt_k, best_idx = k, tie = 0.
  - idx k > 0, cnt_k == best: tie = 1, best_idx unchanged (lowest index wins ties).
  - idx k > 0, cnt_k < best: no change.
  - After idx 3, go to RESULT.
  - Latency: result_req sampled at edge N; COMPARE occupies cycles N+1..N+4; result_valid = 1 from cycle N+5.
- State RESULT:
  - winner, winner_votes and tie are stable and result_valid = 1.
  - seal, result_req and vote_valid are ignored; only reset leaves this state.
  - Before RESULT, winner, winner_votes and tie read 0.
- All counts zero at compare time: winner = 0, winner_votes = 0, tie = 1.
- Read port: rd_count <= counter[rd_sel] every cycle in every state (1-cycle latency). It reflects an increment one cycle after the accepting edge.
- total_votes cannot overflow: max is 4*(2^CNT_W-1) < 2^(CNT_W+2).
- Reset mid-operation (any state, including mid-COMPARE): immediate return to the reset values on that clock edge; no partial result is retained.
- Illegal state encodings recover to COUNT.

Test Plan:
- Votes for parties 2,0,2,3,2 (one-cycle strobes) -> vote_ack ×5; rd_sel = 2 gives rd_count = 3; total_votes = 5; seal, result_req -> result_valid at N+5, winner = 2, winner_votes = 3, tie = 0.
- vote_valid held high 10 cycles with code 1 -> cnt1 = 1, a single vote_ack, total_votes = 1.
- CNT_W = 2, four votes for party 0 -> cnt0 = 3, the 4th vote is not acked, overflow = 1, total_votes = 3; overflow stays 1 afterwards.
- Votes 1,3,1,3 then seal, result_req -> winner = 1, winner_votes = 2, tie = 1; no votes at all -> winner = 0, tie = 1.
- Vote edge and seal in the same cycle -> vote counted and acked, sealed = 1 next cycle; later vote edges -> no ack, counts unchanged; result_req issued while in COUNT -> no effect.
- reset asserted at cycle N+2 of COMPARE -> next cycle all counts 0, sealed = 0, result_valid = 0, state COUNT; a new vote is accepted normally.
